// File: rtl/wb_stage_pkg.sv
// Shared definitions for the MEM/WB writeback stage: writeback source selects,
// load funct3 encodings and writeback FSM states.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    READY     = 2'b01,
    LOAD_WAIT = 2'b10,
    LOAD_RDY  = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data extraction: selects byte/half/word from a word-aligned
// read and sign- or zero-extends it according to funct3.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword selection ignores off[0]; misaligned halves are trapped upstream.
  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback logic: holds the retiring instruction,
// waits for load data (with timeout) and drives the register file write port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd_addr,
  input  logic [1:0]      mem_wb_sel,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic [2:0]      mem_funct3,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_stall,
  output logic            load_err,
  output logic            reg_write,
  output logic [4:0]      WB_rd_addr,
  output logic [XLEN-1:0] WB_rd_data
);

  localparam int CW = (LOAD_TIMEOUT < 1) ? 1 : $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(LOAD_TIMEOUT);

  wb_state_e       r_state;
  wb_state_e       w_state_next;
  logic            r_reg_write;
  logic [4:0]      r_rd;
  logic [1:0]      r_wb_sel;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_pc4;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_load_data;
  logic [CW-1:0]   r_cnt;
  logic            r_load_err;

  logic            w_capture;
  logic            w_load_done;
  logic            w_timeout;
  logic [XLEN-1:0] w_aligned;

  load_align #(.XLEN(XLEN)) u_align (
    .i_rdata  (dmem_rdata),
    .i_off    (r_alu[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // rvalid is only looked at in LOAD_WAIT; data beats a same-cycle timeout.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_load_done  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      LOAD_WAIT: begin
        if (dmem_rvalid) begin
          w_load_done  = 1'b1;
          w_state_next = LOAD_RDY;
        end else if (r_cnt == CNT_LIMIT) begin
          w_timeout    = 1'b1;
          w_state_next = LOAD_RDY;
        end
      end
      default: begin
        w_capture = 1'b1;
        if (!mem_valid) begin
          w_state_next = EMPTY;
        end else if (mem_wb_sel == WB_LOAD) begin
          w_state_next = LOAD_WAIT;
        end else begin
          w_state_next = READY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= '0;
      r_alu       <= '0;
      r_pc4       <= '0;
      r_funct3    <= '0;
      r_load_data <= '0;
      r_cnt       <= '0;
      r_load_err  <= 1'b0;
    end else begin
      r_load_err <= w_timeout;
      if (w_capture) begin
        r_reg_write <= mem_reg_write;
        r_rd        <= mem_rd_addr;
        r_wb_sel    <= mem_wb_sel;
        r_alu       <= mem_alu_result;
        r_pc4       <= mem_pc4;
        r_funct3    <= mem_funct3;
        r_cnt       <= '0;
      end else if (w_load_done) begin
        r_load_data <= w_aligned;
        r_cnt       <= '0;
      end else if (w_timeout) begin
        r_load_data <= '0;
        r_cnt       <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign wb_stall   = (r_state == LOAD_WAIT);
  assign load_err   = r_load_err;
  assign reg_write  = ((r_state == READY) || (r_state == LOAD_RDY)) && r_reg_write && (r_rd != 5'd0);
  assign WB_rd_addr = (r_state != EMPTY) ? r_rd : 5'd0;

  always_comb begin
    WB_rd_data = '0;
    if ((r_state == READY) || (r_state == LOAD_RDY)) begin
      case (r_wb_sel)
        WB_PC4:  WB_rd_data = r_pc4;
        WB_LOAD: WB_rd_data = r_load_data;
        default: WB_rd_data = r_alu;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table of single-instruction writebacks plus
// hand-written timeout, stall-hold and reset-during-load sequences.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int LOAD_TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mem_valid = 1'b0;
  logic            mem_reg_write = 1'b0;
  logic [4:0]      mem_rd_addr = '0;
  logic [1:0]      mem_wb_sel = '0;
  logic [XLEN-1:0] mem_alu_result = '0;
  logic [XLEN-1:0] mem_pc4 = '0;
  logic [2:0]      mem_funct3 = '0;
  logic            dmem_rvalid = 1'b0;
  logic [XLEN-1:0] dmem_rdata = '0;
  logic            wb_stall;
  logic            load_err;
  logic            reg_write;
  logic [4:0]      WB_rd_addr;
  logic [XLEN-1:0] WB_rd_data;

  wb_stage #(.XLEN(XLEN), .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd_addr    (mem_rd_addr),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_result (mem_alu_result),
    .mem_pc4        (mem_pc4),
    .mem_funct3     (mem_funct3),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .wb_stall       (wb_stall),
    .load_err       (load_err),
    .reg_write      (reg_write),
    .WB_rd_addr     (WB_rd_addr),
    .WB_rd_data     (WB_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          delay;
    logic        exp_rw;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    mem_valid      = 1'b1;
    mem_reg_write  = rw;
    mem_rd_addr    = rd;
    mem_wb_sel     = sel;
    mem_alu_result = alu;
    mem_pc4        = pc4;
    mem_funct3     = f3;
  endtask

  task automatic chk_wb(input string tag);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: got empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rw"},    {31'd0, reg_write}, {31'd0, e.rw});
      chk({tag, "_addr"},  {27'd0, WB_rd_addr}, {27'd0, e.addr});
      chk({tag, "_data"},  WB_rd_data, e.data);
      chk({tag, "_err"},   {31'd0, load_err}, {31'd0, e.err});
      chk({tag, "_stall"}, {31'd0, wb_stall}, 32'd0);
      $display("wb %s: rw=%0b rd=%0d data=%h err=%0b", tag, reg_write, WB_rd_addr, WB_rd_data, load_err);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rw"},    {31'd0, reg_write}, 32'd0);
    chk({tag, "_addr"},  {27'd0, WB_rd_addr}, 32'd0);
    chk({tag, "_data"},  WB_rd_data, 32'd0);
    chk({tag, "_stall"}, {31'd0, wb_stall}, 32'd0);
    chk({tag, "_err"},   {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  WB_ALU,  32'h0000_1234, 32'h0, F3_LW,  32'h0,          0,  1'b1, 32'h0000_1234};
    vecs[1]  = '{1'b1, 5'd0,  WB_ALU,  32'h0000_1234, 32'h0, F3_LW,  32'h0,          0,  1'b0, 32'h0000_1234};
    vecs[2]  = '{1'b1, 5'd1,  WB_PC4,  32'h0000_DEAD, 32'h104, F3_LW, 32'h0,         0,  1'b1, 32'h0000_0104};
    vecs[3]  = '{1'b1, 5'd2,  2'b11,   32'hCAFE_0001, 32'h8, F3_LW,  32'h0,          0,  1'b1, 32'hCAFE_0001};
    vecs[4]  = '{1'b0, 5'd9,  WB_ALU,  32'h0000_0099, 32'h0, F3_LW,  32'h0,          0,  1'b0, 32'h0000_0099};
    vecs[5]  = '{1'b1, 5'd7,  WB_LOAD, 32'h0000_1003, 32'h0, F3_LB,  32'h80FF_0011,  3,  1'b1, 32'hFFFF_FF80};
    vecs[6]  = '{1'b1, 5'd8,  WB_LOAD, 32'h0000_2002, 32'h0, F3_LHU, 32'h80FF_0011,  3,  1'b1, 32'h0000_80FF};
    vecs[7]  = '{1'b1, 5'd10, WB_LOAD, 32'h0000_0001, 32'h0, F3_LBU, 32'h1234_A578,  1,  1'b1, 32'h0000_00A5};
    vecs[8]  = '{1'b1, 5'd11, WB_LOAD, 32'h0000_0000, 32'h0, F3_LH,  32'h1234_A578,  2,  1'b1, 32'hFFFF_A578};
    vecs[9]  = '{1'b1, 5'd12, WB_LOAD, 32'h0000_0003, 32'h0, F3_LH,  32'h8001_0000,  1,  1'b1, 32'hFFFF_8001};
    vecs[10] = '{1'b1, 5'd13, WB_LOAD, 32'h0000_0002, 32'h0, F3_LW,  32'hDEAD_BEEF, 16,  1'b1, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 5'd14, WB_LOAD, 32'h0000_0001, 32'h0, 3'b011, 32'h0BAD_F00D,  1,  1'b1, 32'h0BAD_F00D};

    #12 rst = 1'b0;
    #1;
    chk_idle("reset");

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].alu, vecs[i].pc4, vecs[i].f3);
      sb.push_back('{vecs[i].exp_rw, vecs[i].rd, vecs[i].exp_data, 1'b0});
      step();
      mem_valid = 1'b0;
      if (vecs[i].sel == WB_LOAD) begin
        for (int k = 0; k < vecs[i].delay; k++) begin
          chk($sformatf("v%0d_stall%0d", i, k), {31'd0, wb_stall}, 32'd1);
          if (k == vecs[i].delay - 1) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = vecs[i].rdata;
          end
          step();
        end
        dmem_rvalid = 1'b0;
      end
      chk_wb($sformatf("v%0d", i));
      step();
      chk_idle($sformatf("v%0d_after", i));
    end

    // Load timeout, followed by a stray rvalid that must be ignored.
    drive(1'b1, 5'd15, WB_LOAD, 32'h0, 32'h0, F3_LW);
    sb.push_back('{1'b1, 5'd15, 32'h0, 1'b1});
    step();
    mem_valid = 1'b0;
    for (int k = 0; k <= LOAD_TIMEOUT; k++) begin
      chk($sformatf("to_stall%0d", k), {31'd0, wb_stall}, 32'd1);
      chk($sformatf("to_err%0d", k), {31'd0, load_err}, 32'd0);
      step();
    end
    chk_wb("timeout");
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    step();
    chk_idle("stray1");
    step();
    chk_idle("stray2");
    dmem_rvalid = 1'b0;

    // Stall hold: inputs churn during LOAD_WAIT, only the LOAD_RDY-cycle instruction is taken.
    drive(1'b1, 5'd3, WB_LOAD, 32'h0, 32'h0, F3_LW);
    sb.push_back('{1'b1, 5'd3, 32'h1111_2222, 1'b0});
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(20 + k), WB_ALU, $urandom, $urandom, F3_LW);
      chk($sformatf("hold_stall%0d", k), {31'd0, wb_stall}, 32'd1);
      if (k == 3) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
      end
      step();
    end
    dmem_rvalid = 1'b0;
    drive(1'b1, 5'd4, WB_ALU, 32'h0000_4444, 32'h0, F3_LW);
    sb.push_back('{1'b1, 5'd4, 32'h0000_4444, 1'b0});
    chk_wb("hold_load");
    step();
    mem_valid = 1'b0;
    chk_wb("hold_next");
    step();
    chk_idle("hold_after");

    // Reset asserted mid-load drops the load entirely.
    drive(1'b1, 5'd6, WB_LOAD, 32'h0, 32'h0, F3_LW);
    step();
    mem_valid = 1'b0;
    step();
    chk("rst_pre_stall", {31'd0, wb_stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle("rst_now");
    #3 rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    step();
    chk_idle("rst_rvalid1");
    dmem_rvalid = 1'b0;
    step();
    chk_idle("rst_rvalid2");

    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic of the 5-stage RV32I core.
- Captures retiring instructions from the MEM stage and waits for the data-memory response on loads.
- Aligns and sign/zero-extends load data, selects the writeback source, and drives reg_write / WB_rd_addr / WB_rd_data into the register file.
- Asserts wb_stall to freeze upstream stages while a load response is outstanding.

Parameters:
- XLEN, 32, datapath width.
- LOAD_TIMEOUT, 15, max cycles in LOAD_WAIT before abandoning the load (must be ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-high.
- mem_valid  in  1  MEM stage holds a valid instruction (0 = bubble).
- mem_reg_write  in  1  instruction writes rd.
- mem_rd_addr  in  5  destination register.
- mem_wb_sel  in  2  writeback source: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved (treated as ALU).
- mem_alu_result  in  XLEN  ALU result; low 2 bits are the load byte offset.
- mem_pc4  in  XLEN  PC+4 for JAL/JALR.
- mem_funct3  in  3  load width/sign.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  word-aligned load data.
- wb_stall  out  1  upstream must hold; MEM inputs are not sampled.
- load_err  out  1  one-cycle pulse on load timeout.
- reg_write  out  1  register file write enable.
- WB_rd_addr  out  5  register file write address.
- WB_rd_data  out  XLEN  register file write data.

Behaviour:
- Reset (async, immediate): state=EMPTY; all stage registers, timeout counter and outputs = 0. A load in flight is dropped, and any later dmem_rvalid is ignored.
- Capture: at posedge, if !wb_stall, stage registers load all mem_* inputs.
  - mem_valid=0 → next state EMPTY.
  - mem_wb_sel=LOAD → next state LOAD_WAIT.
  - Otherwise → next state READY.
- States:
  - EMPTY → capture rules.
  - READY → capture rules.
  - LOAD_WAIT, dmem_rvalid=1 → latch extracted data, clear counter, go to LOAD_RDY.
  - LOAD_WAIT, counter==LOAD_TIMEOUT → pulse load_err, data=0, go to LOAD_RDY.
  - LOAD_WAIT, otherwise → counter++ and stay.
  - LOAD_RDY → capture rules.
- wb_stall = (state==LOAD_WAIT), combinational from state only.
- dmem_rvalid is sampled only in LOAD_WAIT; it is ignored in every other state.
- Outputs (combinational from registered state):
  - reg_write = (state∈{READY, LOAD_RDY}) && stage_reg_write && stage_rd!=0.
  - WB_rd_addr = stage_rd whenever state!=EMPTY, else 0.
  - WB_rd_data per stage wb_sel: ALU → alu_result, PC+4 → pc4, LOAD → latched load data. It is 0 in EMPTY and LOAD_WAIT.
- Latency:
  - Non-load: write presented the cycle after capture, so the RF updates at the following edge.
  - Load: write presented the cycle after the dmem_rvalid cycle.
- Each captured instruction presents reg_write for exactly one cycle, unless the next capture is itself delayed by stall.
- Load extraction (off = alu_result[1:0]):
  - LB/LBU (000/100): byte rdata[8*off+7:8*off], sign- or zero-extended.
  - LH/LHU (001/101): half at bit 16*off[1], extended; off[0] is ignored (misalignment is handled upstream).
  - LW (010) and all other funct3: full word.
- Simultaneous events:
  - dmem_rvalid in the same cycle the timeout would fire → data wins, no load_err.
  - rst asserted during LOAD_RDY → the write is lost.

Decomposition:
- Shared core package: wb_sel_e enum (WB_ALU, WB_LOAD, WB_PC4), funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), wb_state_e (EMPTY, READY, LOAD_WAIT, LOAD_RDY).
- Sub-module load_align: purely combinational; inputs rdata, off, funct3; output extended data. Reused later by forwarding checks.

Test Plan:
- ALU writeback: capture mem_valid=1, reg_write=1, rd=5, wb_sel=ALU, alu=0x0000_1234 → next cycle reg_write=1, WB_rd_addr=5, WB_rd_data=0x1234; wb_stall stays 0.
- x0 guard: same as the ALU case with rd=0 → reg_write=0 and WB_rd_data=0x1234 still presented.
- LB sign extension: load rd=7, funct3=000, alu=0x1003. dmem_rvalid arrives 3 cycles later with rdata=0x80FF_0011 → wb_stall high for exactly those 3 cycles, then reg_write=1, WB_rd_data=0xFFFF_FF80. Repeat with LHU, off=2 → 0x0000_80FF.
- Timeout: load issued, dmem_rvalid held 0 → load_err pulses once after LOAD_TIMEOUT+1 stall cycles, then WB_rd_data=0 with reg_write=1, and wb_stall drops. A stray rvalid afterwards has no effect.
- Stall hold: while in LOAD_WAIT, change the mem_* inputs every cycle → none are captured. The instruction present on the cycle wb_stall falls is captured and written one cycle after LOAD_RDY.
- Reset mid-load: assert rst in LOAD_WAIT → all outputs 0 immediately; after release, dmem_rvalid=1 → no write, and state remains EMPTY.
